// File: rtl/instr_fetch_ctrl_if.sv
//==============================================================================
// Module   : instr_fetch_ctrl_if
// Purpose  : Fetch-controller bus bundle: instruction memory, redirect and decode handshake.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       imem_addr;
    logic [31:0]       imem_rd;
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [1:0]        fifo_level;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output fifo_level
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output halt,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  fifo_level
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
//==============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : PC owner, 2-entry fetch FIFO, decode handshake and redirect handling.
//            Optional RAW interlock enabled by defining IFETCH_HAZARD_INTERLOCK_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module instr_fetch_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int HAZ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_ctrl_if.master  bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fifo_pc_q    [2];
    logic [ADDR_W-1:0] fifo_pc_d    [2];
    logic [31:0]       fifo_instr_q [2];
    logic [31:0]       fifo_instr_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        level_q, level_d;

    logic              head_valid;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              bubble;
    logic              pop;
    logic              push;
    logic              unused_redir_lsb;

    assign head_valid = (level_q != 2'd0);
    assign head_instr = fifo_instr_q[rd_ptr_q];
    assign head_pc    = fifo_pc_q[rd_ptr_q];

    assign pop  = head_valid & bus.id_ready & ~bubble;
    assign push = ~bus.redirect_valid & ~bus.halt & ((level_q != 2'd2) | pop);

    // Targets are forced word aligned, so the low two bits never reach the PC.
    assign unused_redir_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        pc_d         = pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            level_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = pc_q;
                fifo_instr_d[wr_ptr_q] = bus.imem_rd;
                wr_ptr_d               = ~wr_ptr_q;
                pc_d                   = pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            level_d = level_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= '0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            level_q         <= 2'd0;
        end else begin
            pc_q         <= pc_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
        end
    end

    assign bus.imem_addr  = 32'(pc_q);
    assign bus.fifo_level = level_q;
    assign bus.id_valid   = head_valid;
    assign bus.id_instr   = (head_valid & ~bubble) ? head_instr : 32'h0;
    assign bus.id_pc      = head_valid ? head_pc : '0;

`ifdef IFETCH_HAZARD_INTERLOCK_EN
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;

    // Register 0 doubles as the "no destination" marker; it can never cause a hazard.
    logic [4:0] sb_q [HAZ_DEPTH];
    logic [4:0] sb_d [HAZ_DEPTH];
    logic [4:0] head_rs, head_rt, head_dest;
    logic       head_uses_rt;
    logic       hit;

    assign head_rs = head_instr[25:21];
    assign head_rt = head_instr[20:16];

    always_comb begin
        head_dest    = 5'd0;
        head_uses_rt = 1'b0;
        case (head_instr[31:26])
            c_op_rtype: begin
                head_dest    = head_instr[15:11];
                head_uses_rt = 1'b1;
            end
            c_op_lw, c_op_addi: head_dest    = head_rt;
            c_op_sw, c_op_beq:  head_uses_rt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_q[i] != 5'd0) begin
                if ((head_rs != 5'd0) && (head_rs == sb_q[i])) hit = 1'b1;
                if (head_uses_rt && (head_rt != 5'd0) && (head_rt == sb_q[i])) hit = 1'b1;
            end
        end
    end

    assign bubble = head_valid & hit;

    always_comb begin
        sb_d = sb_q;
        if (head_valid & bus.id_ready) begin
            sb_d[0] = bubble ? 5'd0 : head_dest;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_q[i] <= 5'd0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end
`else
    assign bubble = 1'b0;
`endif

endmodule

`default_nettype wire
